// File: rtl/stream_deserializer_pkg.sv
// Shared types for the stream deserializer: FSM state encoding.
package stream_deserializer_pkg;

    // FILL: assembling a word; HOLD: a finished word is presented downstream.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/stream_deserializer.sv
// Serial-to-parallel converter: packs up to Ratio narrow beats into one wide
// word presented on a valid/ready output, with early close (in_last_i) and flush.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// Valid never depends on ready; once out_valid_o is high the word is held
// stable until out_ready_i is seen. in_ready_o is combinational and is
// forced low while flush_i is high.
module stream_deserializer
    import stream_deserializer_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Ratio     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DataWidth-1:0]         in_data_i,
    input  logic                         in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DataWidth*Ratio-1:0]   out_data_o,
    output logic [Ratio-1:0]             out_strb_o,
    output logic [$clog2(Ratio+1)-1:0]   out_count_o,
    output state_e                       dbg_state_o
);

    localparam int IdxW = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int CntW = $clog2(Ratio + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [DataWidth*Ratio-1:0] data_q, data_d;
    logic [Ratio-1:0]           strb_q, strb_d;

    logic accept;
    logic retire;
    logic complete;

    function automatic logic [CntW-1:0] popcount(input logic [Ratio-1:0] v);
        logic [CntW-1:0] c;
        c = '0;
        for (int k = 0; k < Ratio; k++) begin
            c = c + CntW'(v[k]);
        end
        return c;
    endfunction

    assign out_valid_o = (state_q == ST_HOLD);
    assign in_ready_o  = (!out_valid_o || out_ready_i) && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    assign retire      = out_valid_o && out_ready_i;
    // In HOLD idx_q is 0, so this also covers a completing beat that opens a new word.
    assign complete    = accept && ((idx_q == LastIdx) || in_last_i);

    assign out_data_o  = data_q;
    assign out_strb_o  = strb_q;
    assign out_count_o = popcount(strb_q);
    assign dbg_state_o = state_q;

    // Next-state: lane writes, word close, retire and flush.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        if (flush_i) begin
            state_d = ST_FILL;
            idx_d   = '0;
            data_d  = '0;
            strb_d  = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        data_d[idx_q*DataWidth +: DataWidth] = in_data_i;
                        strb_d[idx_q] = 1'b1;
                        if (complete) begin
                            state_d = ST_HOLD;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (retire) begin
                        // The retiring word is replaced wholesale; a concurrent
                        // beat becomes lane 0 of the next word.
                        data_d  = '0;
                        strb_d  = '0;
                        state_d = ST_FILL;
                        idx_d   = '0;
                        if (accept) begin
                            data_d[DataWidth-1:0] = in_data_i;
                            strb_d[0] = 1'b1;
                            if (complete) begin
                                state_d = ST_HOLD;
                            end else begin
                                idx_d = IdxW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                    data_d  = '0;
                    strb_d  = '0;
                end
            endcase
        end
    end

    // State, beat counter and lane storage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

endmodule

// File: tb/tb_stream_deserializer.sv
// Directed bench for stream_deserializer: Ratio=4 main instance plus a Ratio=1
// instance for the degenerate registered-stage case.
module tb_stream_deserializer;
    import stream_deserializer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic flush = 1'b0;

    // Ratio=4 instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data  = 8'h00;
    logic        in_last  = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic [2:0]  out_count;
    state_e      st4;

    // Ratio=1 instance
    logic        r1_in_valid = 1'b0;
    logic        r1_in_ready;
    logic [7:0]  r1_in_data  = 8'h00;
    logic        r1_in_last  = 1'b0;
    logic        r1_out_valid;
    logic        r1_out_ready = 1'b1;
    logic [7:0]  r1_out_data;
    logic [0:0]  r1_out_strb;
    logic [0:0]  r1_out_count;
    state_e      st1;

    stream_deserializer #(.DataWidth(8), .Ratio(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .out_count_o (out_count),
        .dbg_state_o (st4)
    );

    stream_deserializer #(.DataWidth(8), .Ratio(1)) dut_r1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (r1_in_valid),
        .in_ready_o  (r1_in_ready),
        .in_data_i   (r1_in_data),
        .in_last_i   (r1_in_last),
        .out_valid_o (r1_out_valid),
        .out_ready_i (r1_out_ready),
        .out_data_o  (r1_out_data),
        .out_strb_o  (r1_out_strb),
        .out_count_o (r1_out_count),
        .dbg_state_o (st1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] c);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".strb"},  64'(out_strb),  64'(s));
        check({tag, ".count"}, 64'(out_count), 64'(c));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".data"},  64'(out_data),  64'd0);
        check({tag, ".strb"},  64'(out_strb),  64'd0);
        check({tag, ".count"}, 64'(out_count), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] exp_b;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.state", 64'(st4), 64'(ST_FILL));
        check("reset.r1_valid", 64'(r1_out_valid), 64'd0);

        // Full word, consumer always ready: valid for exactly one cycle.
        out_ready = 1'b1;
        send_beat(8'h11, 1'b0);
        check("full.no_early_valid", 64'(out_valid), 64'd0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        check_word("full", 32'h4433_2211, 4'b1111, 3'd4);
        step();
        check("full.one_cycle", 64'(out_valid), 64'd0);

        // Backpressure: word stable for 5 cycles, input stalled.
        out_ready = 1'b0;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_word("stall", 32'h4433_2211, 4'b1111, 3'd4);
            check("stall.in_ready", 64'(in_ready), 64'd0);
            step();
        end
        // Retire while a new beat is offered: zero-bubble restart in lane 0.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        #1;
        check("retire.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("retire.valid", 64'(out_valid), 64'd0);
        send_beat(8'h66, 1'b1);
        check_word("retire.next", 32'h0000_6655, 4'b0011, 3'd2);
        step();

        // Early close with in_last_i.
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        check_word("short", 32'h0000_BBAA, 4'b0011, 3'd2);
        step();

        // in_last_i on the first beat: 1-beat word.
        send_beat(8'h77, 1'b1);
        check_word("one_beat", 32'h0000_0077, 4'b0001, 3'd1);
        step();

        // Flush after two beats, with a beat offered in the flush cycle.
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        check("flush.in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("flush");
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        send_beat(8'h30, 1'b0);
        check("flush.no_word", 64'(out_valid), 64'd0);
        send_beat(8'h40, 1'b0);
        check_word("after_flush", 32'h4030_2010, 4'b1111, 3'd4);
        step();

        // Flush drops a pending word without a handshake.
        out_ready = 1'b0;
        send_beat(8'h99, 1'b1);
        check("pend.valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_idle("pend_flush");
        out_ready = 1'b1;

        // Reset mid-word.
        send_beat(8'hC1, 1'b0);
        send_beat(8'hC2, 1'b0);
        send_beat(8'hC3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midreset");
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b0);
        send_beat(8'hA3, 1'b0);
        send_beat(8'hA4, 1'b0);
        check_word("after_reset", 32'hA4A3_A2A1, 4'b1111, 3'd4);
        step();
        check("after_reset.single", 64'(out_valid), 64'd0);

        // Ratio=1: continuous beats give one word per cycle.
        r1_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r1_in_valid = 1'b1;
            r1_in_data  = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i));
            step();
            check("r1.valid", 64'(r1_out_valid), 64'd1);
            check("r1.count", 64'(r1_out_count), 64'd1);
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("r1.data", 64'(r1_out_data), 64'(exp_b));
            end
        end
        r1_in_valid = 1'b0;
        step();
        check("r1.drain", 64'(r1_out_valid), 64'd0);
        check("r1.queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
